memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// Memory stage: issues one data-bus request per load/store, waits for completion, extends load data.
// Optional macro MEM_MISALIGN_CHECK_EN: misaligned accesses skip the bus and suppress write-back.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        moduleIn_valid,
    input  logic [63:0] moduleIn_instrAddr,
    input  logic [31:0] moduleIn_instr,
    input  logic [63:0] moduleIn_aluOut,
    input  logic [4:0]  moduleIn_wd,
    input  logic        moduleIn_isWriteBack,
    input  logic        moduleIn_isMemRead,
    input  logic        moduleIn_isMemWrite,
    input  logic [1:0]  moduleIn_memSize,
    input  logic        moduleIn_memUnsigned,
    input  logic [63:0] moduleIn_storeData,
    output logic        moduleOut_valid,
    output logic [63:0] moduleOut_instrAddr,
    output logic [31:0] moduleOut_instr,
    output logic [63:0] moduleOut_aluOut,
    output logic [4:0]  moduleOut_wd,
    output logic        moduleOut_isWriteBack,
    output logic        moduleOut_isMemRead,
    output logic [63:0] moduleOut_memOut,
    output logic        ok_to_proceed,
    input  logic        ok_to_proceed_overall,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state;
    logic [63:0] r_memData;
    logic        r_skipped;
    logic        r_outValid;
    logic [63:0] r_outInstrAddr;
    logic [31:0] r_outInstr;
    logic [63:0] r_outAluOut;
    logic [4:0]  r_outWd;
    logic        r_outIsWriteBack;
    logic        r_outIsMemRead;
    logic [63:0] r_outMemOut;

    logic        w_memOp;
    logic        w_misaligned;
    logic        w_issue;
    logic [63:0] w_shifted;
    logic [63:0] w_loadData;
    logic [7:0]  w_strobeBase;

    assign w_memOp = moduleIn_valid & (moduleIn_isMemRead | moduleIn_isMemWrite);

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (moduleIn_memSize)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = moduleIn_aluOut[0];
            2'd2:    w_misaligned = |moduleIn_aluOut[1:0];
            default: w_misaligned = |moduleIn_aluOut[2:0];
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_issue = (r_state == IDLE) & w_memOp & ~w_misaligned;

    // The request is raised in the same cycle the instruction arrives so zero-wait memory completes at once.
    assign dreq_valid    = ~rst & (w_issue | (r_state == BUSY));
    assign dreq_addr     = moduleIn_aluOut;
    assign dreq_size     = {1'b0, moduleIn_memSize};
    assign dreq_data     = moduleIn_storeData << {moduleIn_aluOut[2:0], 3'b000};
    assign ok_to_proceed = (r_state == DONE) | ((r_state == IDLE) & ~w_memOp);

    always_comb begin
        w_strobeBase = 8'hFF;
        case (moduleIn_memSize)
            2'd0:    w_strobeBase = 8'h01;
            2'd1:    w_strobeBase = 8'h03;
            2'd2:    w_strobeBase = 8'h0F;
            default: w_strobeBase = 8'hFF;
        endcase
    end

    assign dreq_strobe = moduleIn_isMemWrite ? (w_strobeBase << moduleIn_aluOut[2:0]) : 8'h00;
    assign w_shifted   = dresp_data >> {moduleIn_aluOut[2:0], 3'b000};

    always_comb begin
        w_loadData = w_shifted;
        case (moduleIn_memSize)
            2'd0:    w_loadData = {{56{~moduleIn_memUnsigned & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_loadData = {{48{~moduleIn_memUnsigned & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_loadData = {{32{~moduleIn_memUnsigned & w_shifted[31]}}, w_shifted[31:0]};
            default: w_loadData = w_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_memData        <= 64'd0;
            r_skipped        <= 1'b0;
            r_outValid       <= 1'b0;
            r_outInstrAddr   <= 64'd0;
            r_outInstr       <= 32'd0;
            r_outAluOut      <= 64'd0;
            r_outWd          <= 5'd0;
            r_outIsWriteBack <= 1'b0;
            r_outIsMemRead   <= 1'b0;
            r_outMemOut      <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memOp) begin
                        if (w_misaligned) begin
                            r_state   <= DONE;
                            r_memData <= 64'd0;
                            r_skipped <= 1'b1;
                        end else if (dresp_data_ok) begin
                            r_state   <= DONE;
                            r_memData <= moduleIn_isMemRead ? w_loadData : 64'd0;
                            r_skipped <= 1'b0;
                        end else begin
                            r_state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dresp_data_ok) begin
                        r_state   <= DONE;
                        r_memData <= moduleIn_isMemRead ? w_loadData : 64'd0;
                        r_skipped <= 1'b0;
                    end
                end
                DONE: begin
                    if (ok_to_proceed_overall) begin
                        r_state   <= IDLE;
                        r_skipped <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Non-memory instructions pass through in IDLE, so only a completed access forwards captured data.
            if (ok_to_proceed_overall) begin
                r_outValid       <= moduleIn_valid;
                r_outInstrAddr   <= moduleIn_instrAddr;
                r_outInstr       <= moduleIn_instr;
                r_outAluOut      <= moduleIn_aluOut;
                r_outWd          <= moduleIn_wd;
                r_outIsWriteBack <= moduleIn_isWriteBack & ~((r_state == DONE) & r_skipped);
                r_outIsMemRead   <= moduleIn_isMemRead;
                r_outMemOut      <= (r_state == DONE) ? r_memData : 64'd0;
            end else begin
                r_outValid       <= 1'b0;
            end
        end
    end

    assign moduleOut_valid       = r_outValid;
    assign moduleOut_instrAddr   = r_outInstrAddr;
    assign moduleOut_instr       = r_outInstr;
    assign moduleOut_aluOut      = r_outAluOut;
    assign moduleOut_wd          = r_outWd;
    assign moduleOut_isWriteBack = r_outIsWriteBack;
    assign moduleOut_isMemRead   = r_outIsMemRead;
    assign moduleOut_memOut      = r_outMemOut;
endmodule
